fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the instruction memory bank. Owns the program counter and drives the memory's word-indexed PC and read enable. Absorbs the memory's 1-cycle registered read latency and hands {inst, pc} to decode over a valid/ready handshake. Handles decode back-pressure through a 2-entry buffer and branch/jump redirects from execute.

Parameters:
PC_W, 8, width of word-indexed PC; matches the memory address port
INST_W, 32, instruction width
RESET_PC, 0, first word address fetched after reset
BUF_DEPTH, 2, output buffer entries; fixed at 2, other values unsupported

Ports:
pclk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
mem_pc  out  PC_W  word address to the instruction memory; equals the fetch_pc register
mem_read_en  out  1  read request; memory samples it with mem_pc at the rising edge
mem_inst  in  INST_W  memory data; valid the cycle after a sampled request
redirect_valid  in  1  execute requests a PC change (taken branch or JAL)
redirect_pc  in  PC_W  redirect target word address
out_valid  out  1  {out_inst, out_pc} valid to decode
out_ready  in  1  decode accepts this cycle
out_inst  out  INST_W  fetched instruction (buffer head)
out_pc  out  PC_W  word address of out_inst

Behaviour:
- Reset (rst=1 at an edge): fetch_pc<=RESET_PC; buffer count<=0, entries<=0; inflight<=0. mem_read_en=0 and out_valid=0 while rst=1. After reset out_inst=0 and out_pc=0.
- State:
  - fetch_pc (PC_W)
  - inflight bit plus inflight_pc (PC of the request whose data is on mem_inst this cycle)
  - 2-entry FIFO of {inst, pc} with count 0..2
- pop = out_valid & out_ready.
- out_valid = (count!=0) & !redirect_valid. out_inst and out_pc come from the FIFO head, which is registered, so there is no mem_inst-to-output bypass.
- Issue: mem_read_en = !rst & !redirect_valid & ((count + inflight - pop) < 2). This is a combinational credit check that guarantees no overflow.
- On issue edge: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 mod 2^PC_W (255 wraps to 0). With no issue: inflight<=0 and fetch_pc holds.
- Response: if inflight=1 and redirect_valid=0, mem_inst/inflight_pc are pushed at the edge.
- Push and pop in the same cycle are legal at any count; the count is unchanged.
- Latency: request sampled at edge E; data pushed at edge E+1; out_valid from cycle after E+1 (2 cycles request-to-valid).
- Steady state, out_ready=1: one instruction per cycle after the first 2 cycles.
- Stall (out_ready=0): the buffer fills to 2 and issue stops. Nothing is lost, duplicated or reordered. Issue resumes in the cycle decode pops.
- Redirect (redirect_valid=1), which takes priority over everything else:
  - count<=0 (buffer flushed).
  - The in-flight response is discarded and inflight<=0.
  - No issue this cycle.
  - fetch_pc<=redirect_pc.
  - out_valid forced 0 this cycle, so no handshake occurs.
  - Next cycle issues redirect_pc; out_valid for it is 3 cycles after the redirect cycle.
  - Back-to-back redirects: the last one wins.
- Redirect while rst=1: reset wins.
- mem_inst is ignored whenever inflight=0. The memory returns 0 for unrequested cycles, and that 0 must never be buffered.

Decomposition:
- Shared package rv_fetch_pkg holds:
  - constants PC_W, INST_W, RESET_PC
  - NOP_INST=32'h00000013
  - typedef fetch_pkt_t {inst, pc}
- One sub-module: fetch_skid_fifo. It is the 2-entry FIFO with push, pop, flush, count and head outputs; flush has priority over push.
- The credit check and PC logic stay in fetch_unit.

Test Plan:
- Reset then out_ready=1, memory preloaded word k = 32'h1000_0000+k -> mem_pc 0,1,2,... one per cycle; first out_valid 2 cycles after reset release with out_pc=0, out_inst=32'h10000000; then contiguous pc 1,2,3.
- out_ready=0 for 6 cycles after the first valid -> count reaches 2, mem_read_en falls to 0, mem_pc holds; on release, out_pc sequence is 0,1,2,3 with no gap >0 cycles after resume and no duplicates.
- Redirect to 8'h40 while count=2 and inflight=1 -> out_valid 0 in redirect cycle and the next 2; next accepted packet is out_pc=8'h40, and stale PCs are never emitted.
- Redirect in the same cycle as pop with out_ready=1 -> no handshake recorded; the stale head is not emitted.
- Run from redirect_pc=8'hFE -> out_pc sequence FE, FF, 00, 01 (wrap).
- Assert rst mid-stream with count=2 -> the cycle after the reset edge has out_valid=0 and mem_read_en=0; after release, fetch restarts at RESET_PC with no stale packet.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants and packet type for the instruction-fetch stage.
package rv_fetch_pkg;

  localparam int unsigned PC_W      = 8;
  localparam int unsigned INST_W    = 32;
  localparam int unsigned BUF_DEPTH = 2;

  localparam logic [PC_W-1:0]   RESET_PC = '0;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory request/response, redirect and decode handshake signals of the fetch stage.
interface fetch_unit_if;
  import rv_fetch_pkg::*;

  logic [PC_W-1:0]   mem_pc;
  logic              mem_read_en;
  logic [INST_W-1:0] mem_inst;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;

  modport master (
    output mem_pc, mem_read_en, out_valid, out_inst, out_pc,
    input  mem_inst, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_pc, mem_read_en, out_valid, out_inst, out_pc,
    output mem_inst, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry {inst, pc} buffer between the memory response and decode; flush beats push.
module fetch_skid_fifo
  import rv_fetch_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       push_i,
  input  fetch_pkt_t push_pkt_i,
  input  logic       pop_i,
  output logic [1:0] count_o,
  output fetch_pkt_t head_o
);

  fetch_pkt_t mem_q [BUF_DEPTH];
  fetch_pkt_t mem_d [BUF_DEPTH];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_i) begin
        mem_d[wr_ptr_q] = push_pkt_i;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited reads and buffers responses for decode.
module fetch_unit
  import rv_fetch_pkg::*;
(
  input logic          pclk,
  input logic          rst,
  fetch_unit_if.master bus
);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;

  logic [1:0]  count;
  logic [1:0]  credit;
  fetch_pkt_t  head;
  fetch_pkt_t  push_pkt;
  logic        pop, push, issue;

  always_comb begin
    bus.out_valid = (count != 2'd0) && !rst && !bus.redirect_valid;
    pop           = bus.out_valid && bus.out_ready;
    // Slots already spoken for once this edge settles: buffered + returning - leaving.
    credit        = count + {1'b0, inflight_q} - {1'b0, pop};
    issue         = !rst && !bus.redirect_valid && (credit < 2'd2);
    push          = inflight_q && !bus.redirect_valid;
    push_pkt      = '{inst: bus.mem_inst, pc: inflight_pc_q};

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + 1'b1;
      inflight_pc_d = fetch_pc_q;
    end

    bus.mem_pc      = fetch_pc_q;
    bus.mem_read_en = issue;
    bus.out_inst    = head.inst;
    bus.out_pc      = head.pc;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk_i      (pclk),
    .rst_i      (rst),
    .flush_i    (bus.redirect_valid),
    .push_i     (push),
    .push_pkt_i (push_pkt),
    .pop_i      (pop),
    .count_o    (count),
    .head_o     (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, then random ready/redirect/reset vs a stream model.
module tb_fetch_unit;
  import rv_fetch_pkg::*;

  logic pclk;
  logic rst;

  fetch_unit_if bus ();

  fetch_unit dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Instruction memory: word k holds 0x1000_0000 + k, returns 0 when not requested.
  always @(posedge pclk) begin
    if (bus.mem_read_en) bus.mem_inst <= 32'h1000_0000 + 32'(bus.mem_pc);
    else                 bus.mem_inst <= '0;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit         rs;
    bit         rdy;
    bit         rv;
    logic [7:0] rpc;
    bit         ev;
    bit         er;
    logic [7:0] emem;
    int         ck;    // 0: ignore head, 1: head = memory word epc, 2: head all-zero
    logic [7:0] epc;
  } vec_t;

  function automatic vec_t mk(bit rs, bit rdy, bit rv, logic [7:0] rpc, bit ev, bit er,
                              logic [7:0] emem, int ck, logic [7:0] epc);
    vec_t v;
    v.rs = rs; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.er = er; v.emem = emem; v.ck = ck; v.epc = epc;
    return v;
  endfunction

  vec_t       tbl[$];
  logic [7:0] exp_pc;
  int         gap;
  int         n_acc;
  bit         r_rst, r_rv, r_rdy;
  logic [7:0] r_rpc;

  initial begin
    rst                = 1'b1;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.mem_inst       = '0;

    //            rs rdy rv rpc    ev er mem   ck pc
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00));  // startup
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h01, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h02, 1, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h03, 1, 8'h01));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h04, 1, 8'h02));  // stall, buffer fills
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h04, 1, 8'h02));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h04, 1, 8'h02));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h04, 1, 8'h02));  // resume issues at pop
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h05, 1, 8'h03));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h06, 1, 8'h04));
    tbl.push_back(mk(0, 1, 1, 8'h40, 0, 0, 8'h07, 0, 8'h00));  // redirect over a pop
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h40, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h41, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h42, 1, 8'h40));
    tbl.push_back(mk(0, 1, 1, 8'hFE, 0, 0, 8'h43, 0, 8'h00));  // redirect near the top
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'hFE, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'hFF, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h00, 1, 8'hFE));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h01, 1, 8'hFF));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h02, 1, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h03, 1, 8'h01));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h04, 1, 8'h02));
    tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h04, 1, 8'h02));
    tbl.push_back(mk(1, 1, 1, 8'h80, 0, 0, 8'h04, 0, 8'h00));  // reset (beats redirect)
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 2, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'h01, 0, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h02, 1, 8'h00));
    tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'h03, 1, 8'h01));

    repeat (2) @(posedge pclk);
    #1;
    @(negedge pclk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rden", 32'(bus.mem_read_en), 32'd0);
    chk("rst_mem_pc", 32'(bus.mem_pc), 32'(RESET_PC));
    chk("rst_out_pc", 32'(bus.out_pc), 32'd0);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    @(posedge pclk);
    #1;

    foreach (tbl[i]) begin
      rst                = tbl[i].rs;
      bus.out_ready      = tbl[i].rdy;
      bus.redirect_valid = tbl[i].rv;
      bus.redirect_pc    = tbl[i].rpc;
      @(negedge pclk);
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_rden", i), 32'(bus.mem_read_en), 32'(tbl[i].er));
      chk($sformatf("v%0d_mem_pc", i), 32'(bus.mem_pc), 32'(tbl[i].emem));
      if (tbl[i].ck == 1) begin
        chk($sformatf("v%0d_out_pc", i), 32'(bus.out_pc), 32'(tbl[i].epc));
        chk($sformatf("v%0d_out_inst", i), bus.out_inst, 32'h1000_0000 + 32'(tbl[i].epc));
      end else if (tbl[i].ck == 2) begin
        chk($sformatf("v%0d_out_pc", i), 32'(bus.out_pc), 32'd0);
        chk($sformatf("v%0d_out_inst", i), bus.out_inst, 32'd0);
      end
      @(posedge pclk);
      #1;
    end

    // Random phase: accepted packets must follow program order from the last redirect/reset.
    exp_pc = 8'h02;
    gap    = 0;
    n_acc  = 0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 149) == 0);
      r_rv  = ($urandom_range(0, 14) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rpc = 8'($urandom);
      rst                = r_rst;
      bus.out_ready      = r_rdy;
      bus.redirect_valid = r_rv;
      bus.redirect_pc    = r_rpc;
      @(negedge pclk);
      if (r_rst) begin
        chk("rnd_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rnd_rst_rden", 32'(bus.mem_read_en), 32'd0);
        exp_pc = RESET_PC;
        gap    = 0;
      end else if (r_rv) begin
        chk("rnd_redir_valid", 32'(bus.out_valid), 32'd0);
        chk("rnd_redir_rden", 32'(bus.mem_read_en), 32'd0);
        exp_pc = r_rpc;
        gap    = 0;
      end else if (bus.out_valid && r_rdy) begin
        chk("rnd_out_pc", 32'(bus.out_pc), 32'(exp_pc));
        chk("rnd_out_inst", bus.out_inst, 32'h1000_0000 + 32'(exp_pc));
        chk("rnd_gap", 32'(gap <= 2), 32'd1);
        exp_pc = exp_pc + 8'd1;
        gap    = 0;
        n_acc++;
      end else if (r_rdy) begin
        gap++;
      end
      @(posedge pclk);
      #1;
    end
    chk("rnd_final_gap", 32'(gap <= 2), 32'd1);
    chk("rnd_throughput", 32'(n_acc > 500), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
